// File: rtl/pll_reset_sequencer_pkg.sv
// Shared types and constants for the PLL reset sequencer.
package pll_seq_pkg;

  typedef enum logic [1:0] {
    PLL_RESET = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } pll_seq_state_t;

  localparam int unsigned RETRY_W   = 4;
  localparam int unsigned RETRY_MAX = (1 << RETRY_W) - 1;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// PLL status/control bundle between the sequencer and its environment.
interface pll_reset_sequencer_if;
  import pll_seq_pkg::*;

  logic               pll_locked;
  logic               clear_status;
  logic               pll_rst;
  logic               sys_reset;
  logic               pll_ready;
  logic               lock_lost;
  logic [RETRY_W-1:0] retry_count;

  modport master (
    output pll_locked, clear_status,
    input  pll_rst, sys_reset, pll_ready, lock_lost, retry_count
  );

  modport slave (
    input  pll_locked, clear_status,
    output pll_rst, sys_reset, pll_ready, lock_lost, retry_count
  );
endinterface

// File: rtl/pll_reset_sequencer_bit_sync.sv
// Multi-flop synchroniser for a single asynchronous status bit.
module bit_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sr;

  always_ff @(posedge clk) begin
    if (!reset_n) sr <= '0;
    else          sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];
endmodule

// File: rtl/pll_reset_sequencer.sv
// Sequences PLL reset, lock qualification and system reset release with retry on timeout.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RESET_CYCLES  = 16,
  parameter int unsigned LOCK_TIMEOUT  = 1000000,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input logic                   clk,
  input logic                   reset_n,
  pll_reset_sequencer_if.slave  bus
);
  localparam int unsigned CNT_MAX = max3(RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int unsigned CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  pll_seq_state_t     state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [RETRY_W-1:0] retry_next;
  logic               lost_next;
  logic               locked_s;
  logic               retry_inc;
  logic               lost_set;

  bit_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (bus.pll_locked),
    .q       (locked_s)
  );

  // Next-state, counter and sticky status logic
  always_comb begin
    state_next = state;
    retry_inc  = 1'b0;
    lost_set   = 1'b0;
    case (state)
      PLL_RESET: begin
        if (cnt == CNT_W'(RESET_CYCLES - 1)) state_next = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          state_next = STABLE;
        end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
          state_next = PLL_RESET;
          retry_inc  = 1'b1;
        end
      end
      STABLE: begin
        if (!locked_s)                               state_next = WAIT_LOCK;
        else if (cnt == CNT_W'(STABLE_CYCLES - 1))   state_next = RUN;
      end
      RUN: begin
        if (!locked_s) begin
          state_next = PLL_RESET;
          lost_set   = 1'b1;
        end
      end
      default: state_next = PLL_RESET;
    endcase

    cnt_next = (state_next != state) ? '0 : cnt + CNT_W'(1);

    // Set/increment events take precedence over clear_status
    retry_next = bus.retry_count;
    if (retry_inc) begin
      if (bus.clear_status)                              retry_next = RETRY_W'(1);
      else if (bus.retry_count != RETRY_W'(RETRY_MAX))   retry_next = bus.retry_count + RETRY_W'(1);
    end else if (bus.clear_status) begin
      retry_next = '0;
    end

    lost_next = bus.lock_lost;
    if (lost_set)              lost_next = 1'b1;
    else if (bus.clear_status) lost_next = 1'b0;
  end

  // State, counter and registered outputs derived from the state being entered
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state           <= PLL_RESET;
      cnt             <= '0;
      bus.pll_rst     <= 1'b1;
      bus.sys_reset   <= 1'b1;
      bus.pll_ready   <= 1'b0;
      bus.lock_lost   <= 1'b0;
      bus.retry_count <= '0;
    end else begin
      state           <= state_next;
      cnt             <= cnt_next;
      bus.pll_rst     <= (state_next == PLL_RESET);
      bus.sys_reset   <= (state_next != RUN);
      bus.pll_ready   <= (state_next == RUN);
      bus.lock_lost   <= lost_next;
      bus.retry_count <= retry_next;
    end
  end
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Randomised and directed bench for pll_reset_sequencer against a phase/elapsed-time model.
module tb_pll_reset_sequencer;
  localparam int RC   = 4;
  localparam int LT   = 20;
  localparam int SC   = 8;
  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  pll_reset_sequencer_if bus ();

  pll_reset_sequencer #(
    .RESET_CYCLES  (RC),
    .LOCK_TIMEOUT  (LT),
    .STABLE_CYCLES (SC),
    .SYNC_STAGES   (SYNC)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: which phase of the sequence we are in and how long we have been there.
  localparam int PH_RESET = 0, PH_WAIT = 1, PH_QUAL = 2, PH_RUN = 3;
  int m_phase = PH_RESET;
  int m_since = 0;
  int m_retry = 0;
  int m_lost  = 0;
  int m_hist [SYNC];

  always @(posedge clk) begin
    int seen, np, bump, drop;
    if (!reset_n) begin
      m_phase = PH_RESET; m_since = 0; m_retry = 0; m_lost = 0;
      for (int i = 0; i < SYNC; i++) m_hist[i] = 0;
    end else begin
      seen = m_hist[SYNC-1];
      np = m_phase; bump = 0; drop = 0;
      if (m_phase == PH_RESET) begin
        if (m_since + 1 >= RC) np = PH_WAIT;
      end else if (m_phase == PH_WAIT) begin
        if (seen == 1) np = PH_QUAL;
        else if (m_since + 1 >= LT) begin np = PH_RESET; bump = 1; end
      end else if (m_phase == PH_QUAL) begin
        if (seen == 0) np = PH_WAIT;
        else if (m_since + 1 >= SC) np = PH_RUN;
      end else begin
        if (seen == 0) begin np = PH_RESET; drop = 1; end
      end
      m_since = (np == m_phase) ? m_since + 1 : 0;
      m_phase = np;
      if (bump == 1)              m_retry = bus.clear_status ? 1 : ((m_retry < 15) ? m_retry + 1 : 15);
      else if (bus.clear_status)  m_retry = 0;
      if (drop == 1)              m_lost = 1;
      else if (bus.clear_status)  m_lost = 0;
      for (int i = SYNC - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = int'(bus.pll_locked);
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    chk("pll_rst",     int'(bus.pll_rst),     (m_phase == PH_RESET) ? 1 : 0);
    chk("sys_reset",   int'(bus.sys_reset),   (m_phase == PH_RUN) ? 0 : 1);
    chk("pll_ready",   int'(bus.pll_ready),   (m_phase == PH_RUN) ? 1 : 0);
    chk("lock_lost",   int'(bus.lock_lost),   m_lost);
    chk("retry_count", int'(bus.retry_count), m_retry);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset(input int lock_val);
    reset_n = 1'b0;
    bus.pll_locked = lock_val[0];
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    bus.pll_locked   = 1'b0;
    bus.clear_status = 1'b0;

    // Nominal bring-up: lock rises before edge 10, release at edge 20
    do_reset(0);
    chk("rst_pll_rst",   int'(bus.pll_rst),     1);
    chk("rst_sys_reset", int'(bus.sys_reset),   1);
    chk("rst_retry",     int'(bus.retry_count), 0);
    ticks(3);
    chk("e3_pll_rst", int'(bus.pll_rst), 1);
    tick();
    chk("e4_pll_rst", int'(bus.pll_rst), 0);
    ticks(5);
    bus.pll_locked = 1'b1;
    ticks(10);
    chk("e19_ready", int'(bus.pll_ready), 0);
    tick();
    chk("e20_ready", int'(bus.pll_ready), 1);
    chk("e20_sysrst", int'(bus.sys_reset), 0);

    // Lock loss in RUN coinciding with clear_status: set wins
    bus.pll_locked = 1'b0;
    ticks(2);
    bus.clear_status = 1'b1;
    tick();
    bus.clear_status = 1'b0;
    chk("lost_set_wins", int'(bus.lock_lost), 1);
    chk("lost_sysrst",   int'(bus.sys_reset), 1);
    bus.pll_locked = 1'b1;
    ticks(30);
    chk("reseq_ready", int'(bus.pll_ready), 1);
    chk("reseq_lost",  int'(bus.lock_lost), 1);
    bus.clear_status = 1'b1;
    tick();
    bus.clear_status = 1'b0;
    chk("lost_cleared", int'(bus.lock_lost), 0);

    // Glitch during qualification restarts the wait without a retry
    do_reset(1);
    ticks(8);
    bus.pll_locked = 1'b0;
    tick();
    bus.pll_locked = 1'b1;
    ticks(25);
    chk("glitch_retry", int'(bus.retry_count), 0);

    // Never locks: retries saturate at 15 and sys_reset stays high
    do_reset(0);
    ticks(16 * (RC + LT) + 10);
    chk("sat_retry",  int'(bus.retry_count), 15);
    chk("sat_sysrst", int'(bus.sys_reset), 1);

    // Reset mid WAIT_LOCK with three retries accumulated
    do_reset(0);
    ticks(3 * (RC + LT) + 6);
    chk("pre_rst_retry", int'(bus.retry_count), 3);
    do_reset(0);
    chk("post_rst_retry",  int'(bus.retry_count), 0);
    chk("post_rst_pllrst", int'(bus.pll_rst), 1);

    // Random lock behaviour, status clears and occasional resets
    for (int seg = 0; seg < 60; seg++) begin
      int len;
      bus.pll_locked = 1'($urandom_range(0, 3) != 0);
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(5, 60));
      for (int c = 0; c < len; c++) begin
        bus.clear_status = 1'($urandom_range(0, 15) == 0);
        reset_n = 1'($urandom_range(0, 299) != 0);
        tick();
      end
      bus.clear_status = 1'b0;
      reset_n = 1'b1;
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
